// File: rtl/hidden_layer_mac_if.sv
// Handshake and data bundle between a parameter/feature source and one
// hidden_layer_mac bank: start request, packed operands, busy/done status and results.
interface hidden_layer_mac_if #(
  parameter int N_IN  = 62,
  parameter int N_NEU = 8
);
  logic                      start;
  logic [N_IN*8-1:0]         x_in;
  logic [N_IN*N_NEU*8-1:0]   weight;
  logic [N_NEU*8-1:0]        bias;
  logic                      busy;
  logic                      done;
  logic [N_NEU*8-1:0]        y_out;

  modport master (
    output start, x_in, weight, bias,
    input  busy, done, y_out
  );

  modport slave (
    input  start, x_in, weight, bias,
    output busy, done, y_out
  );
endinterface

// File: rtl/hidden_layer_mac.sv
// Sequential 8x8 signed MAC for one hidden-layer neuron bank (one product per cycle).
// Activation: `HIDDEN_RELU_EN defined -> clamp to [0,127]; undefined -> saturate to [-128,127].
module hidden_layer_mac #(
  parameter int N_IN  = 62,
  parameter int N_NEU = 8,
  parameter int FRAC  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  hidden_layer_mac_if.slave bus
);

  localparam int ACC_W = 2*8 + 8;
  localparam int JW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int NW    = (N_NEU > 1) ? $clog2(N_NEU) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(N_IN - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N_NEU - 1);
  localparam logic signed [ACC_W-1:0] POS_MAX = 127;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    STORE,
    DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [NW-1:0]            n_q, n_d;
  logic [JW-1:0]            j_q, j_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic signed [7:0]        x_q [N_IN];
  logic signed [7:0]        y_q [N_NEU];
  logic signed [7:0]        x_bytes [N_IN];

  logic                     x_load;
  logic                     y_store;
  logic signed [7:0]        x_cur;
  logic signed [7:0]        w_cur;
  logic signed [15:0]       prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic [NW-1:0]            bias_idx;
  logic signed [7:0]        bias_byte;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [7:0]        act_val;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_x_unpack
      assign x_bytes[gi] = bus.x_in[8*gi +: 8];
    end
    for (gi = 0; gi < N_NEU; gi++) begin : g_y_pack
      assign bus.y_out[8*gi +: 8] = y_q[gi];
    end
  endgenerate

  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // Operand fetch: captured feature j and the live weight byte for (n, j).
  always_comb begin
    x_cur    = x_q[j_q];
    w_cur    = bus.weight[8*(int'(n_q)*N_IN + int'(j_q)) +: 8];
    prod     = x_cur * w_cur;
    prod_ext = {{(ACC_W-16){prod[15]}}, prod};
  end

  // Bias preload: neuron 0 when starting, otherwise the neuron after the one being stored.
  always_comb begin
    bias_idx  = (state_q == IDLE) ? '0 : n_q + NW'(1);
    bias_byte = bus.bias[8*int'(bias_idx) +: 8];
    bias_ext  = {{(ACC_W-8-FRAC){bias_byte[7]}}, bias_byte, {FRAC{1'b0}}};
  end

  always_comb begin
    shifted = acc_q >>> FRAC;
`ifdef HIDDEN_RELU_EN
    if (shifted < 0) begin
      act_val = 8'sd0;
    end else if (shifted > POS_MAX) begin
      act_val = 8'sd127;
    end else begin
      act_val = shifted[7:0];
    end
`else
    if (shifted > POS_MAX) begin
      act_val = 8'sd127;
    end else if (shifted < -POS_MAX - 1) begin
      act_val = -8'sd128;
    end else begin
      act_val = shifted[7:0];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    j_d     = j_q;
    acc_d   = acc_q;
    x_load  = 1'b0;
    y_store = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_load  = 1'b1;
          n_d     = '0;
          j_d     = '0;
          acc_d   = bias_ext;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + prod_ext;
        j_d   = j_q + JW'(1);
        if (j_q == J_LAST) begin
          state_d = STORE;
        end
      end
      STORE: begin
        y_store = 1'b1;
        if (n_q == N_LAST) begin
          state_d = DONE;
        end else begin
          n_d     = n_q + NW'(1);
          j_d     = '0;
          acc_d   = bias_ext;
          state_d = MAC;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Status flags follow the next state so they line up with the state register.
    busy_d = (state_d == MAC) || (state_d == STORE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        x_q[i] <= '0;
      end
      for (int i = 0; i < N_NEU; i++) begin
        y_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (x_load) begin
        for (int i = 0; i < N_IN; i++) begin
          x_q[i] <= x_bytes[i];
        end
      end
      if (y_store) begin
        y_q[n_q] <= act_val;
      end
    end
  end

endmodule

// File: tb/tb_hidden_layer_mac.sv
// Self-checking bench for hidden_layer_mac: directed corner cases, random vectors
// against a plain-arithmetic neuron model, latency/busy timing and async reset.
module tb_hidden_layer_mac;

  localparam int N_IN  = 62;
  localparam int N_NEU = 8;

  logic clk;
  logic rst_n;

  hidden_layer_mac_if #(.N_IN(N_IN), .N_NEU(N_NEU)) bus_if ();

  hidden_layer_mac #(.N_IN(N_IN), .N_NEU(N_NEU), .FRAC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int xs [N_IN];
  int ws [N_NEU][N_IN];
  int bs [N_NEU];

  // Reference neuron: bias scaled by 2^4 plus dot product, rescaled, then activation.
  function automatic logic [7:0] model(input int n);
    int acc;
    int v;
    acc = bs[n] * 16;
    for (int j = 0; j < N_IN; j++) begin
      acc += xs[j] * ws[n][j];
    end
    v = acc >>> 4;
`ifdef HIDDEN_RELU_EN
    if (v < 0) v = 0;
    if (v > 127) v = 127;
`else
    if (v < -128) v = -128;
    if (v > 127) v = 127;
`endif
    return 8'(v);
  endfunction

  task automatic drive_params();
    for (int j = 0; j < N_IN; j++) begin
      bus_if.x_in[8*j +: 8] = 8'(xs[j]);
    end
    for (int n = 0; n < N_NEU; n++) begin
      bus_if.bias[8*n +: 8] = 8'(bs[n]);
      for (int j = 0; j < N_IN; j++) begin
        bus_if.weight[8*(n*N_IN + j) +: 8] = 8'(ws[n][j]);
      end
    end
  endtask

  task automatic fill(input int xv, input int wv, input int bv);
    for (int j = 0; j < N_IN; j++) xs[j] = xv;
    for (int n = 0; n < N_NEU; n++) begin
      bs[n] = bv;
      for (int j = 0; j < N_IN; j++) ws[n][j] = wv;
    end
  endtask

  task automatic fill_random();
    for (int j = 0; j < N_IN; j++) xs[j] = int'($urandom_range(0, 255)) - 128;
    for (int n = 0; n < N_NEU; n++) begin
      bs[n] = int'($urandom_range(0, 255)) - 128;
      for (int j = 0; j < N_IN; j++) ws[n][j] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // Start is driven just after edge 0 and sampled at edge 1; edges are counted from there.
  // x_in is scrambled once the start has been taken to prove it was captured.
  task automatic run_op(input string tag, input int restart_at,
                        output int done_edge, output int busy_cnt,
                        output int done_cnt, output logic [N_NEU*8-1:0] y_at_done);
    done_edge = -1;
    busy_cnt  = 0;
    done_cnt  = 0;
    y_at_done = '0;
    drive_params();
    @(posedge clk);
    #1 bus_if.start = 1'b1;
    for (int k = 1; k <= 700; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        bus_if.start = 1'b0;
        for (int j = 0; j < N_IN; j++) bus_if.x_in[8*j +: 8] = 8'($urandom);
      end
      if (k == restart_at) bus_if.start = 1'b1;
      else if (k == restart_at + 1) bus_if.start = 1'b0;
      if (bus_if.busy === 1'b1) busy_cnt++;
      if (bus_if.done === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = k;
          y_at_done = bus_if.y_out;
        end
      end
      if (done_edge >= 0 && k >= done_edge + 3) break;
    end
    bus_if.start = 1'b0;
    $display("txn %s: done_edge=%0d busy_cycles=%0d done_cycles=%0d y_out=%h",
             tag, done_edge, busy_cnt, done_cnt, y_at_done);
  endtask

  task automatic test_reset();
    checks++;
    if (bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", bus_if.busy);
    end
    checks++;
    if (bus_if.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", bus_if.done);
    end
    checks++;
    if (bus_if.y_out !== '0) begin
      errors++;
      $display("FAIL reset_y_out: got %h expected 0", bus_if.y_out);
    end
  endtask

  task automatic test_constant_bias();
    int de, bc, dc;
    logic [N_NEU*8-1:0] y;
    fill(0, 0, 3);
    for (int j = 0; j < N_IN; j++) xs[j] = int'($urandom_range(0, 255)) - 128;
    run_op("const_bias", -10, de, bc, dc, y);
    for (int n = 0; n < N_NEU; n++) begin
      checks++;
      if (y[8*n +: 8] !== 8'h03) begin
        errors++;
        $display("FAIL const_bias n=%0d: got %h expected 03", n, y[8*n +: 8]);
      end
    end
  endtask

  task automatic test_single_tap();
    int de, bc, dc;
    logic [N_NEU*8-1:0] y;
    fill(0, 0, 1);
    xs[0] = 32;
    for (int n = 0; n < N_NEU; n++) ws[n][0] = 8;
    run_op("single_tap", -10, de, bc, dc, y);
    for (int n = 0; n < N_NEU; n++) begin
      checks++;
      if (y[8*n +: 8] !== 8'h11) begin
        errors++;
        $display("FAIL single_tap n=%0d: got %h expected 11", n, y[8*n +: 8]);
      end
    end
  endtask

  task automatic test_saturation();
    int de, bc, dc;
    logic [N_NEU*8-1:0] y;
    logic [7:0] exp_neg;
    fill(16, 16, 0);
    run_op("pos_sat", -10, de, bc, dc, y);
    for (int n = 0; n < N_NEU; n++) begin
      checks++;
      if (y[8*n +: 8] !== 8'h7F) begin
        errors++;
        $display("FAIL pos_sat n=%0d: got %h expected 7f", n, y[8*n +: 8]);
      end
    end
`ifdef HIDDEN_RELU_EN
    exp_neg = 8'h00;
`else
    exp_neg = 8'h80;
`endif
    fill(-128, 127, 0);
    run_op("neg_sat", -10, de, bc, dc, y);
    for (int n = 0; n < N_NEU; n++) begin
      checks++;
      if (y[8*n +: 8] !== exp_neg) begin
        errors++;
        $display("FAIL neg_sat n=%0d: got %h expected %h", n, y[8*n +: 8], exp_neg);
      end
    end
  endtask

  task automatic test_negative_bias();
    int de, bc, dc;
    logic [N_NEU*8-1:0] y;
    logic [7:0] exp_v;
`ifdef HIDDEN_RELU_EN
    exp_v = 8'h00;
`else
    exp_v = 8'hFB;
`endif
    fill(0, 0, -5);
    for (int j = 0; j < N_IN; j++) xs[j] = int'($urandom_range(0, 255)) - 128;
    run_op("neg_bias", -10, de, bc, dc, y);
    for (int n = 0; n < N_NEU; n++) begin
      checks++;
      if (y[8*n +: 8] !== exp_v) begin
        errors++;
        $display("FAIL neg_bias n=%0d: got %h expected %h", n, y[8*n +: 8], exp_v);
      end
    end
  endtask

  task automatic test_random();
    int de, bc, dc;
    logic [N_NEU*8-1:0] y;
    for (int t = 0; t < 4; t++) begin
      fill_random();
      run_op("random", -10, de, bc, dc, y);
      for (int n = 0; n < N_NEU; n++) begin
        checks++;
        if (y[8*n +: 8] !== model(n)) begin
          errors++;
          $display("FAIL random t=%0d n=%0d: got %h expected %h", t, n, y[8*n +: 8], model(n));
        end
      end
    end
  endtask

  // Latency, busy width and single-cycle done, with a stray start mid-run and hold in IDLE.
  task automatic test_timing();
    int de, bc, dc;
    logic [N_NEU*8-1:0] y;
    fill_random();
    run_op("timing", 200, de, bc, dc, y);
    checks++;
    if (de != 505) begin
      errors++;
      $display("FAIL done_edge: got %0d expected 505", de);
    end
    checks++;
    if (bc != 504) begin
      errors++;
      $display("FAIL busy_cycles: got %0d expected 504", bc);
    end
    checks++;
    if (dc != 1) begin
      errors++;
      $display("FAIL done_cycles: got %0d expected 1", dc);
    end
    for (int n = 0; n < N_NEU; n++) begin
      checks++;
      if (y[8*n +: 8] !== model(n)) begin
        errors++;
        $display("FAIL timing_result n=%0d: got %h expected %h", n, y[8*n +: 8], model(n));
      end
    end
    repeat (5) @(posedge clk);
    #1;
    for (int n = 0; n < N_NEU; n++) begin
      checks++;
      if (bus_if.y_out[8*n +: 8] !== model(n)) begin
        errors++;
        $display("FAIL idle_hold n=%0d: got %h expected %h", n, bus_if.y_out[8*n +: 8], model(n));
      end
    end
  endtask

  task automatic test_back_to_back();
    int de, bc, dc;
    logic [N_NEU*8-1:0] y;
    for (int t = 0; t < 2; t++) begin
      fill_random();
      run_op("back_to_back", -10, de, bc, dc, y);
      checks++;
      if (de != 505) begin
        errors++;
        $display("FAIL b2b_done_edge t=%0d: got %0d expected 505", t, de);
      end
      for (int n = 0; n < N_NEU; n++) begin
        checks++;
        if (y[8*n +: 8] !== model(n)) begin
          errors++;
          $display("FAIL b2b t=%0d n=%0d: got %h expected %h", t, n, y[8*n +: 8], model(n));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int de, bc, dc;
    logic [N_NEU*8-1:0] y;
    fill(0, 0, 3);
    drive_params();
    @(posedge clk);
    #1 bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    repeat (99) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    $display("txn async_reset: busy=%b done=%b y_out=%h", bus_if.busy, bus_if.done, bus_if.y_out);
    checks++;
    if (bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_busy: got %b expected 0", bus_if.busy);
    end
    checks++;
    if (bus_if.done !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_done: got %b expected 0", bus_if.done);
    end
    checks++;
    if (bus_if.y_out !== '0) begin
      errors++;
      $display("FAIL async_rst_y_out: got %h expected 0", bus_if.y_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fill_random();
    run_op("after_reset", -10, de, bc, dc, y);
    checks++;
    if (de != 505) begin
      errors++;
      $display("FAIL post_rst_done_edge: got %0d expected 505", de);
    end
    for (int n = 0; n < N_NEU; n++) begin
      checks++;
      if (y[8*n +: 8] !== model(n)) begin
        errors++;
        $display("FAIL post_rst n=%0d: got %h expected %h", n, y[8*n +: 8], model(n));
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus_if.start  = 1'b0;
    bus_if.x_in   = '0;
    bus_if.weight = '0;
    bus_if.bias   = '0;
    #22;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_constant_bias();
    test_single_tap();
    test_saturation();
    test_negative_bias();
    test_random();
    test_timing();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
